// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED time-slicing arbiter.
//   LED_W / IO_LED_W / PATTERN_W : display field widths
//   state_e                      : arbiter FSM states
//   dwell_cnt_w()                : width of the dwell down-counter
package led_arb_pkg;

  localparam int unsigned LED_W     = 8;
  localparam int unsigned IO_LED_W  = 24;
  localparam int unsigned PATTERN_W = 32;

  typedef enum logic [0:0] {
    IDLE,
    HOLD
  } state_e;

  // Counter only ever holds DWELL_CYCLES-1 down to 0; keep at least one bit.
  function automatic int unsigned dwell_cnt_w(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search.
//   req    : request vector
//   ptr    : last winner; ptr+1 has highest priority, ptr itself lowest
//   valid  : any request found
//   onehot : one-hot winner (zero when !valid)
//   idx    : winner index (zero when !valid)
module rr_pick
  import led_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [NUM_REQ-1:0]         onehot,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    cand   = '0;
    // Offsets 1..NUM_REQ so that ptr itself is examined last.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    if (valid) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin time-slicing arbiter for the 8 board LEDs and 24 IO-shield LEDs.
//   clk, rst   : clock, synchronous active-high reset
//   req        : per-requester level request
//   pattern    : requester i pattern at [32*i+31:32*i]
//   brightness : global PWM duty (only when LED_ARB_PWM_EN is defined)
//   grant      : one-hot owner, zero when idle
//   LED        : owner pattern [31:24]
//   IO_LED     : owner pattern [23:0]
// Build option: define LED_ARB_PWM_EN to add brightness gating of the outputs.
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*PATTERN_W-1:0]   pattern,
`ifdef LED_ARB_PWM_EN
  input  logic [7:0]                     brightness,
`endif
  output logic [NUM_REQ-1:0]             grant,
  output logic [LED_W-1:0]               LED,
  output logic [IO_LED_W-1:0]            IO_LED
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = dwell_cnt_w(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [PATTERN_W-1:0]   out_q, out_d;
  logic [PATTERN_W-1:0]   sel_pat, disp_d;
  logic                   rel;

  logic                   pick_valid;
  logic [NUM_REQ-1:0]     pick_onehot;
  logic [IDX_W-1:0]       pick_idx;

  // One search serves both the idle pick and the release pick: in HOLD, ptr is
  // the owner, so the owner is naturally searched last.
  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    rel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          state_d = HOLD;
          ptr_d   = pick_idx;
          cnt_d   = RELOAD;
          grant_d = pick_onehot;
        end
      end
      HOLD: begin
        rel = (cnt_q == '0) || !req[ptr_q];
        if (rel) begin
          if (pick_valid) begin
            ptr_d   = pick_idx;
            cnt_d   = RELOAD;
            grant_d = pick_onehot;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            grant_d = '0;
          end
        end else begin
          cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Slice of whoever owns the display after this edge.
  always_comb begin
    sel_pat = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ptr_d == IDX_W'(i)) begin
        sel_pat = pattern[i*PATTERN_W +: PATTERN_W];
      end
    end
    disp_d = (state_d == HOLD) ? sel_pat : '0;
  end

`ifdef LED_ARB_PWM_EN
  logic [7:0] pwm_cnt_q;
  logic       gate;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= 8'h00;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'h01;
    end
  end

  // 8'hFF means fully on; otherwise duty is brightness/256.
  always_comb begin
    gate  = (brightness == 8'hFF) || (pwm_cnt_q < brightness);
    out_d = gate ? disp_d : '0;
  end
`else
  always_comb begin
    out_d = disp_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      out_q   <= out_d;
    end
  end

  assign grant  = grant_q;
  assign LED    = out_q[PATTERN_W-1 -: LED_W];
  assign IO_LED = out_q[IO_LED_W-1:0];

endmodule

// File: tb/tb_led_arbiter.sv
// Directed self-checking bench for led_arbiter (NUM_REQ=4, DWELL_CYCLES=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [31:0]  pat [4];
  logic [127:0] pattern;
  logic [3:0]   grant;
  logic [7:0]   LED;
  logic [23:0]  IO_LED;
`ifdef LED_ARB_PWM_EN
  logic [7:0]   brightness;
`endif

  int n_checks;
  int n_errs;

  assign pattern = {pat[3], pat[2], pat[1], pat[0]};

  led_arbiter #(
    .NUM_REQ      (4),
    .DWELL_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .pattern    (pattern),
`ifdef LED_ARB_PWM_EN
    .brightness (brightness),
`endif
    .grant      (grant),
    .LED        (LED),
    .IO_LED     (IO_LED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [31:0] p);
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_led"}, 32'(LED), 32'(p[31:24]));
    check({tag, "_io"}, 32'(IO_LED), 32'(p[23:0]));
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    pat[0] = 32'h81_123450;
    pat[1] = 32'h42_abcde1;
    pat[2] = 32'h24_55aa02;
    pat[3] = 32'h18_0f0f03;
`ifdef LED_ARB_PWM_EN
    brightness = 8'hFF;
`endif

    // Reset held 3 cycles with every request up.
    rst = 1'b1;
    req = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      check_out("reset", 4'b0000, 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Full contention: each owner holds exactly 4 cycles, twice round.
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) check_out("rot_edge", 4'(1 << (k % 4)), pat[k % 4]);
        else        check("rot_hold", 32'(grant), 32'(1 << (k % 4)));
        @(negedge clk);
      end
    end

    // Owner 0 just granted; only req[2] remains -> owner drops, 2 takes over.
    req = 4'b0100;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check_out("sole", 4'b0100, pat[2]);
    end
    // Mid-dwell (two cycles left) req[0] rises; takes over at expiry.
    req = 4'b0101;
    @(negedge clk);
    check("sole_wait1", 32'(grant), 32'h4);
    @(negedge clk);
    check("sole_wait2", 32'(grant), 32'h4);
    @(negedge clk);
    check_out("sole_takeover", 4'b0001, pat[0]);

    // Early drop: 0 drops, 1 takes over, then 1 drops with req[3] waiting.
    req = 4'b0010;
    @(negedge clk);
    check_out("drop_to1", 4'b0010, pat[1]);
    req = 4'b1000;
    @(negedge clk);
    check_out("drop_to3", 4'b1000, pat[3]);
    req = 4'b0010;
    @(negedge clk);
    check_out("drop_back1", 4'b0010, pat[1]);
    req = 4'b0000;
    @(negedge clk);
    check_out("drop_idle", 4'b0000, 32'h0);
    @(negedge clk);
    check_out("idle_stay", 4'b0000, 32'h0);

    // Reset while owner 1 holds the display.
    req = 4'b0010;
    @(negedge clk);
    check_out("pre_rst", 4'b0010, pat[1]);
    rst = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    check_out("mid_rst", 4'b0000, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_out("post_rst", 4'b0001, pat[0]);

    // Live pattern change of the owner shows one cycle later.
    pat[0] = 32'hff00ff00;
    @(negedge clk);
    check_out("live_pat", 4'b0001, 32'hff00ff00);

`ifdef LED_ARB_PWM_EN
    begin
      int hi;
      req    = 4'b0001;
      pat[0] = 32'hffffffff;
      brightness = 8'd64;
      repeat (3) @(negedge clk);
      hi = 0;
      repeat (256) begin
        @(negedge clk);
        if (LED[0] && IO_LED[0]) hi++;
      end
      check("pwm_64", 32'(hi), 32'd64);
      brightness = 8'd255;
      repeat (3) @(negedge clk);
      hi = 0;
      repeat (256) begin
        @(negedge clk);
        if (LED == 8'hff && IO_LED == 24'hffffff) hi++;
      end
      check("pwm_255", 32'(hi), 32'd256);
      brightness = 8'd0;
      repeat (3) @(negedge clk);
      hi = 0;
      repeat (256) begin
        @(negedge clk);
        if (LED != 8'h00 || IO_LED != 24'h0) hi++;
      end
      check("pwm_0", 32'(hi), 32'd0);
      check("pwm_grant", 32'(grant), 32'h1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
